// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-attached RAM controller: command encoding and
// per-port pointer state.
package spi_ram_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        NOADDR = 1'b0,
        ARMED  = 1'b1
    } ptr_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port storage for spi_ram_ctrl. Synchronous write, registered
// read-first output that only changes on a read. The read register
// resets to 0; the array contents are never cleared.
module spi_ram_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array write; no reset so the storage maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Registered read; holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder, write/read pointers, pointer FSMs and status flags for
// a RAM behind an SPI slave. Define SPI_RAM_PARITY_EN to store an even
// parity bit with every word and flag mismatches on read.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              cmd_err,
    output logic              parity_err
);

`ifdef SPI_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    cmd_e                 cmd;
    logic [DATA_W-1:0]    payload;
    logic [ADDR_SIZE-1:0] addr;
    logic                 addr_ok;

    ptr_state_e           wr_state, wr_state_nxt;
    ptr_state_e           rd_state, rd_state_nxt;
    logic [ADDR_SIZE-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_SIZE-1:0] rd_ptr, rd_ptr_nxt;

    logic                 mem_we, mem_re, err_nxt;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [MEM_W-1:0]     mem_wdata, mem_rdata;

    assign cmd     = cmd_e'(din[DATA_W+1:DATA_W]);
    assign payload = din[DATA_W-1:0];
    assign addr    = payload[ADDR_SIZE-1:0];
    assign addr_ok = ({1'b0, addr} < (ADDR_SIZE+1)'(MEM_DEPTH));

`ifdef SPI_RAM_PARITY_EN
    assign mem_wdata = {^payload, payload};
`else
    assign mem_wdata = payload;
`endif

    // Pointers wrap at the configured depth, not at the address width.
    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        return (p == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode one command per valid cycle into pointer/FSM updates and array access.
    always_comb begin
        wr_state_nxt = wr_state;
        rd_state_nxt = rd_state;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = wr_ptr;
        err_nxt      = 1'b0;
        if (rx_valid) begin
            case (cmd)
                WR_ADDR: begin
                    if (addr_ok) begin
                        wr_state_nxt = ARMED;
                        wr_ptr_nxt   = addr;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                WR_DATA: begin
                    if (wr_state == ARMED) begin
                        mem_we     = 1'b1;
                        mem_addr   = wr_ptr;
                        wr_ptr_nxt = ptr_inc(wr_ptr);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (addr_ok) begin
                        rd_state_nxt = ARMED;
                        rd_ptr_nxt   = addr;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (rd_state == ARMED) begin
                        mem_re     = 1'b1;
                        mem_addr   = rd_ptr;
                        rd_ptr_nxt = ptr_inc(rd_ptr);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: err_nxt = 1'b1;
            endcase
        end
    end

    // State, pointers and the one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= NOADDR;
            rd_state <= NOADDR;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            tx_valid <= mem_re;
            cmd_err  <= err_nxt;
        end
    end

    spi_ram_array #(
        .WIDTH (MEM_W),
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign dout = mem_rdata[DATA_W-1:0];

`ifdef SPI_RAM_PARITY_EN
    // Stored word plus parity must have even weight.
    assign parity_err = tx_valid & (^mem_rdata);
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: table-driven command vectors, a
// read-data scoreboard, and hand sequences for out-of-range addresses,
// reset during a read and (SPI_RAM_PARITY_EN) parity errors.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    typedef struct {
        logic       vld;
        cmd_e       cmd;
        logic [7:0] pay;
        logic       exp_err;
        logic       exp_tx;
        logic [7:0] exp_dout;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic       perr;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;

    logic [7:0] dout, dout2;
    logic       tx_valid, cmd_err, parity_err;
    logic       tx_valid2, cmd_err2, parity_err2;

    int n_vec = 0;
    int n_err = 0;
    rd_t exp_q[$];
    vec_t tbl[22];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.DATA_W(8), .ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(dout), .tx_valid(tx_valid), .cmd_err(cmd_err), .parity_err(parity_err)
    );

    spi_ram_ctrl #(.DATA_W(8), .ADDR_SIZE(8), .MEM_DEPTH(200)) dut2 (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(dout2), .tx_valid(tx_valid2), .cmd_err(cmd_err2), .parity_err(parity_err2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic vld, input cmd_e c, input logic [7:0] p,
                               input logic e, input logic t, input logic [7:0] d);
        vec_t r;
        r.vld = vld; r.cmd = c; r.pay = p; r.exp_err = e; r.exp_tx = t; r.exp_dout = d;
        return r;
    endfunction

    // Present one command for exactly one rising edge; returns 1 ns after it.
    task automatic send(input logic vld, input cmd_e c, input logic [7:0] p);
        @(negedge clk);
        rx_valid = vld;
        din      = {c, p};
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_rd(input logic [7:0] d, input logic pe);
        rd_t r;
        r.dout = d;
        r.perr = pe;
        exp_q.push_back(r);
    endtask

    // Scoreboard: every tx_valid on the 256-deep instance must match a queued read.
    always @(negedge clk) begin
        if (tx_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_tx: got dout 0x%0h, expected no read", dout);
            end else begin
                rd_t e;
                e = exp_q.pop_front();
                chk("rd_dout", 32'(dout), 32'(e.dout));
                chk("rd_parity_err", 32'(parity_err), 32'(e.perr));
            end
        end
    end

    initial begin
        tbl[0]  = v(1, WR_DATA, 8'h55, 1, 0, 8'h00);
        tbl[1]  = v(1, RD_DATA, 8'h00, 1, 0, 8'h00);
        tbl[2]  = v(1, WR_ADDR, 8'h10, 0, 0, 8'h00);
        tbl[3]  = v(1, WR_DATA, 8'hA5, 0, 0, 8'h00);
        tbl[4]  = v(1, RD_ADDR, 8'h10, 0, 0, 8'h00);
        tbl[5]  = v(1, RD_DATA, 8'h00, 0, 1, 8'hA5);
        tbl[6]  = v(0, RD_DATA, 8'h00, 0, 0, 8'h00);
        tbl[7]  = v(1, WR_ADDR, 8'hFE, 0, 0, 8'h00);
        tbl[8]  = v(1, WR_DATA, 8'h11, 0, 0, 8'h00);
        tbl[9]  = v(1, WR_DATA, 8'h22, 0, 0, 8'h00);
        tbl[10] = v(1, WR_DATA, 8'h33, 0, 0, 8'h00);
        tbl[11] = v(1, RD_ADDR, 8'hFE, 0, 0, 8'h00);
        tbl[12] = v(1, RD_DATA, 8'h00, 0, 1, 8'h11);
        tbl[13] = v(1, RD_DATA, 8'h00, 0, 1, 8'h22);
        tbl[14] = v(1, RD_DATA, 8'h00, 0, 1, 8'h33);
        tbl[15] = v(1, RD_ADDR, 8'h00, 0, 0, 8'h00);
        tbl[16] = v(1, RD_DATA, 8'h00, 0, 1, 8'h33);
        tbl[17] = v(1, WR_ADDR, 8'hC8, 0, 0, 8'h00);
        tbl[18] = v(1, WR_DATA, 8'h5A, 0, 0, 8'h00);
        tbl[19] = v(1, RD_ADDR, 8'hC8, 0, 0, 8'h00);
        tbl[20] = v(1, RD_DATA, 8'h00, 0, 1, 8'h5A);
        tbl[21] = v(0, WR_DATA, 8'hFF, 0, 0, 8'h00);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_cmd_err", 32'(cmd_err), 0);
        chk("rst_parity_err", 32'(parity_err), 0);
        chk("rst_dout2", 32'(dout2), 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven main sequence
        foreach (tbl[i]) begin
            if (tbl[i].exp_tx) push_rd(tbl[i].exp_dout, 1'b0);
            send(tbl[i].vld, tbl[i].cmd, tbl[i].pay);
            chk($sformatf("v%0d_cmd_err", i), 32'(cmd_err), 32'(tbl[i].exp_err));
            chk($sformatf("v%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].exp_tx));
        end
        @(negedge clk);
        chk("pulses_drop_tx", 32'(tx_valid), 0);
        chk("dout_held", 32'(dout), 32'h5A);

        // Out-of-range address on a 200-deep RAM leaves wr_ptr untouched
        send(1, WR_ADDR, 8'h05);
        send(1, WR_DATA, 8'h66);
        send(1, WR_ADDR, 8'h05);
        send(1, WR_ADDR, 8'hC8);
        chk("oor_cmd_err2", 32'(cmd_err2), 1);
        chk("oor_cmd_err_256", 32'(cmd_err), 0);
        send(1, WR_DATA, 8'h77);
        chk("oor_next_err2", 32'(cmd_err2), 0);
        send(1, RD_ADDR, 8'h05);
        push_rd(8'h66, 1'b0);
        send(1, RD_DATA, 8'h00);
        chk("oor_tx_valid2", 32'(tx_valid2), 1);
        chk("oor_dout2", 32'(dout2), 32'h77);

        // Reset asserted while a read is in flight
        send(1, RD_ADDR, 8'h10);
        @(negedge clk);
        rx_valid = 1'b1;
        din      = {RD_DATA, 8'h00};
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_kill_tx", 32'(tx_valid), 0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst      = 1'b0;
        send(1, RD_DATA, 8'h00);
        chk("post_rst_rd_err", 32'(cmd_err), 1);
        chk("post_rst_rd_tx", 32'(tx_valid), 0);

`ifdef SPI_RAM_PARITY_EN
        // Corrupt the stored parity bit and read back
        send(1, WR_ADDR, 8'h20);
        send(1, WR_DATA, 8'h0F);
        dut.u_array.mem[8'h20][8] = 1'b1;
        send(1, RD_ADDR, 8'h20);
        push_rd(8'h0F, 1'b1);
        send(1, RD_DATA, 8'h00);
        chk("par_tx_valid", 32'(tx_valid), 1);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
